mdu_sched: RTL
==============

Name: mdu_sched

Overview:
- Sequences the shared multiply/divide unit (HI/LO) attached to the E stage of the 5-stage pipeline.
- Accepts mult/div/mthi/mtlo/mfhi/mflo requests from the E-stage controller and models the fixed multi-cycle latency with a busy counter.
- Owns the HI/LO registers.
- Drives a stall request to the hazard unit so D-stage MDU instructions wait while the unit is occupied.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (and madd family); legal range 1..15
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- E_md_op  in  4  MDU operation of the E-stage instruction (encoding in package; 0 = none)
- E_A  in  32  forwarded rs value (E_Fw_Grs)
- E_B  in  32  forwarded rt value (E_Fw_Grt)
- D_is_md  in  1  D-stage instruction is any MDU op (mult/div/mf*/mt*/madd family)
- busy  out  1  unit computing
- start  out  1  a mult/div is accepted this cycle
- HI  out  32  HI register
- LO  out  32  LO register
- E_md_out  out  32  HI for mfhi, LO for mflo, else 0 (combinational, current register value)
- D_md_stall  out  1  stall request to hazard unit; OR-ed into the pipeline stall

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset: state IDLE, counter 0, HI=LO=0, busy=0, start=0. Reset mid-operation aborts the operation with no HI/LO update.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down.
- start = (state==IDLE) && E_md_op is a mult/div class op. Combinational; 0 while RUN.
- At the start edge (cycle T):
  - Compute the 64-bit result from E_A/E_B into a pending register.
  - Load counter with MUL_CYCLES or DIV_CYCLES.
  - Go to RUN.
- RUN:
  - Counter decrements each cycle.
  - When counter==1, the edge commits pending to {HI,LO} and returns to IDLE.
  - busy is high for cycles T+1..T+N; new HI/LO are visible at T+N+1.
- mult: signed 64-bit product. multu: unsigned. HI=upper 32 bits, LO=lower 32 bits.
- div/divu: LO=quotient, HI=remainder.
  - Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divisor 0: the op still occupies DIV_CYCLES; HI/LO stay unchanged at commit.
- mthi/mtlo in IDLE: write E_A to HI/LO at the edge, no busy.
- mfhi/mflo: combinational read.
- Any E_md_op arriving while RUN is a protocol violation. It is ignored: no start, no HI/LO write.
- D_md_stall = D_is_md && (start || busy).
- Same-cycle mthi/mtlo and commit cannot occur: the stall guarantees exclusion. If they do, the commit wins.
- E_md_op codes not defined in the package are treated as none.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: ops madd, maddu, msub, msubu are accepted.
  - Latency is MUL_CYCLES.
  - Commit writes {HI,LO} ± product, computed signed/unsigned per op, modulo 2^64.
  - The accumulate uses the {HI,LO} captured at start.
- Undefined: those codes decode as none and are never accepted. start stays 0.

Decomposition:
- Package mdu_pkg holds:
  - MD_OP codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12.
  - Width constant MD_OP_W=4.
  - Helper predicates is_mul/is_div.
- Sub-module mdu_arith: combinational 64-bit result computation (op, A, B, old HI/LO) → {hi,lo}, div0 flag.
- The FSM, counter and registers stay in mdu_sched.

Test Plan:
- mult A=0xFFFFFFFD(-3), B=5 → start=1 at T, busy 5 cycles, at T+6 HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- div A=0xFFFFFFF9(-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles; divu 7/2 → LO=3, HI=1.
- Stall: mult issued with D_is_md=1 held → D_md_stall=1 for T..T+5, 0 at T+6; D_is_md=0 → D_md_stall=0 throughout.
- div by zero, HI=0x11, LO=0x22 preset via mthi/mtlo → busy 10 cycles, HI/LO remain 0x11/0x22; mfhi gives E_md_out=0x11.
- reset asserted at T+3 of a mult → next cycle busy=0, HI=LO=0, no later commit.
- MDU_MADD_EN defined: HI=0, LO=0xFFFFFFFF, maddu 1*1 → HI=1, LO=0. Undefined: same op → start=0, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU op codes, state type and op-class predicates (madd family gated by MDU_MADD_EN)
package mdu_pkg;

    localparam int MD_OP_W = 4;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Ops that occupy the unit for MUL_CYCLES; madd family only when MDU_MADD_EN is defined.
    function automatic logic is_mul(input logic [MD_OP_W-1:0] op);
        logic r;
        r = 1'b0;
        case (op)
            MD_MULT, MD_MULTU: r = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational 64-bit mult/div/accumulate result (madd family gated by MDU_MADD_EN)
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    input  logic [31:0]        hi,
    input  logic [31:0]        lo,
    output logic [31:0]        res_hi,
    output logic [31:0]        res_lo,
    output logic               div0
);

    logic        sgn;
    logic [63:0] prod;
    logic [63:0] acc;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] dvs;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        sgn  = (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
        prod = sgn ? ({{32{a[31]}}, a} * {{32{b[31]}}, b})
                   : ({32'b0, a} * {32'b0, b});
        div0 = is_div(op) && (b == 32'b0);

        // Divide magnitudes, then fix signs: quotient truncates toward zero,
        // remainder follows the dividend. A zero divisor is replaced to keep X out.
        mag_a = (sgn && a[31]) ? (~a + 32'd1) : a;
        mag_b = (sgn && b[31]) ? (~b + 32'd1) : b;
        dvs   = (b == 32'b0) ? 32'd1 : mag_b;
        quo   = mag_a / dvs;
        rem   = mag_a % dvs;
        if (sgn && (a[31] ^ b[31])) quo = ~quo + 32'd1;
        if (sgn && a[31])           rem = ~rem + 32'd1;

        acc = {hi, lo};
        case (op)
            MD_MULT, MD_MULTU: acc = prod;
            MD_DIV, MD_DIVU:   acc = {rem, quo};
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU: acc = {hi, lo} + prod;
            MD_MSUB, MD_MSUBU: acc = {hi, lo} - prod;
`endif
            default:           acc = {hi, lo};
        endcase
        res_hi = acc[63:32];
        res_lo = acc[31:0];
    end

endmodule

// File: rtl/mdu_sched.sv
// rtl/mdu_sched.sv - MDU sequencer: busy counter, HI/LO ownership, D-stage stall (madd family with MDU_MADD_EN)
module mdu_sched
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [MD_OP_W-1:0] E_md_op,
    input  logic [31:0]        E_A,
    input  logic [31:0]        E_B,
    input  logic               D_is_md,
    output logic               busy,
    output logic               start,
    output logic [31:0]        HI,
    output logic [31:0]        LO,
    output logic [31:0]        E_md_out,
    output logic               D_md_stall
);

    mdu_state_e  state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [63:0] pend;
    logic        pend_div0;
    logic        commit;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_div0;

    mdu_arith u_arith (
        .op     (E_md_op),
        .a      (E_A),
        .b      (E_B),
        .hi     (HI),
        .lo     (LO),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (res_div0)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start     = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_mul(E_md_op) || is_div(E_md_op)) begin
                    start     = 1'b1;
                    state_nxt = ST_RUN;
                    cnt_nxt   = is_div(E_md_op) ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
                end
            end
            ST_RUN: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            pend      <= 64'd0;
            pend_div0 <= 1'b0;
            HI        <= 32'd0;
            LO        <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (start) begin
                pend      <= {res_hi, res_lo};
                pend_div0 <= res_div0;
            end
            // Commit has priority; op inputs are ignored entirely while running.
            if (commit) begin
                if (!pend_div0) begin
                    HI <= pend[63:32];
                    LO <= pend[31:0];
                end
            end else if (state == ST_IDLE) begin
                if (E_md_op == MD_MTHI) HI <= E_A;
                if (E_md_op == MD_MTLO) LO <= E_A;
            end
        end
    end

    assign busy       = (state == ST_RUN);
    assign D_md_stall = D_is_md && (start || busy);
    assign E_md_out   = (E_md_op == MD_MFHI) ? HI :
                        (E_md_op == MD_MFLO) ? LO : 32'd0;

endmodule
